// File: rtl/mem_io_pkg.sv
// Shared address map and decoded-target type for the memory-stage load/store bridge.
package mem_io_pkg;

  localparam logic [31:0] LEDR_ADDR     = 32'h0000_7000;
  localparam logic [31:0] LEDG_ADDR     = 32'h0000_7010;
  localparam logic [31:0] HEX_LO_ADDR   = 32'h0000_7020;
  localparam logic [31:0] HEX_HI_ADDR   = 32'h0000_7024;
  localparam logic [31:0] LCD_ADDR      = 32'h0000_7030;
  localparam logic [31:0] SW_ADDR       = 32'h0000_7800;
  localparam logic [31:0] KEY_ADDR      = 32'h0000_7810;
  localparam logic [31:0] KEY_EDGE_ADDR = 32'h0000_7814;
  localparam logic [31:0] CYCLE_ADDR    = 32'h0000_7820;

  typedef enum logic [3:0] {
    SEL_DMEM,
    SEL_LEDR,
    SEL_LEDG,
    SEL_HEX_LO,
    SEL_HEX_HI,
    SEL_LCD,
    SEL_SW,
    SEL_KEY,
    SEL_KEY_EDGE,
    SEL_CYCLE,
    SEL_NONE
  } io_sel_e;

  // Word-granular compare: byte-offset bits are ignored.
  function automatic logic word_match(logic [31:0] addr, logic [31:0] target);
    return addr[31:2] == target[31:2];
  endfunction

endpackage

// File: rtl/mem_io_bridge_dmem.sv
// Word-addressed data RAM: synchronous write, asynchronous read, no reset.
module dmem #(
  parameter int unsigned DMEM_WORDS = 512
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(DMEM_WORDS)-1:0] addr,
  input  logic [31:0]                   wdata,
  output logic [31:0]                   rdata
);

  logic [31:0] mem_q [DMEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_io_bridge.sv
// Memory-stage load/store target: data RAM, LED/HEX/LCD output registers, synchronized
// switch/key inputs with sticky key-press flags, and a free-running cycle counter.
module mem_io_bridge #(
  parameter int unsigned DMEM_WORDS = 512,
  parameter logic [31:0] DMEM_BASE  = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemWriteM,
  output logic [31:0] ReadDataM,
  input  logic [31:0] io_sw,
  input  logic [3:0]  io_key,
  output logic [31:0] io_ledr,
  output logic [31:0] io_ledg,
  output logic [63:0] io_hex,
  output logic [31:0] io_lcd
);
  import mem_io_pkg::*;

  localparam int unsigned AW        = $clog2(DMEM_WORDS);
  localparam logic [31:0] DMEM_LAST = DMEM_BASE + 32'(4 * DMEM_WORDS) - 32'd1;

  io_sel_e     sel;
  logic        dmem_we;
  logic [31:0] dmem_rdata;

  logic [31:0] ledr_q, ledg_q, lcd_q, cycle_q, cycle_d;
  logic [63:0] hex_q;
  logic [31:0] sw_meta_q, sw_sync_q;
  logic [3:0]  key_meta_q, key_sync_q, key_prev_q;
  logic [3:0]  key_edge_q, key_edge_d, key_press;

  always_comb begin
    sel = SEL_NONE;
    if (ALUResultM >= DMEM_BASE && ALUResultM <= DMEM_LAST) sel = SEL_DMEM;
    else if (word_match(ALUResultM, LEDR_ADDR))     sel = SEL_LEDR;
    else if (word_match(ALUResultM, LEDG_ADDR))     sel = SEL_LEDG;
    else if (word_match(ALUResultM, HEX_LO_ADDR))   sel = SEL_HEX_LO;
    else if (word_match(ALUResultM, HEX_HI_ADDR))   sel = SEL_HEX_HI;
    else if (word_match(ALUResultM, LCD_ADDR))      sel = SEL_LCD;
    else if (word_match(ALUResultM, SW_ADDR))       sel = SEL_SW;
    else if (word_match(ALUResultM, KEY_ADDR))      sel = SEL_KEY;
    else if (word_match(ALUResultM, KEY_EDGE_ADDR)) sel = SEL_KEY_EDGE;
    else if (word_match(ALUResultM, CYCLE_ADDR))    sel = SEL_CYCLE;
  end

  // RAM has no reset, so a store overlapping reset is suppressed here instead.
  assign dmem_we = MemWriteM && (sel == SEL_DMEM) && !rst;

  dmem #(
    .DMEM_WORDS(DMEM_WORDS)
  ) u_dmem (
    .clk  (clk),
    .we   (dmem_we),
    .addr (ALUResultM[AW+1:2]),
    .wdata(WriteDataM),
    .rdata(dmem_rdata)
  );

  // Keys are active-low; a press is a released-to-pressed step of the synchronized level.
  assign key_press = key_prev_q & ~key_sync_q;

  always_comb begin
    key_edge_d = key_edge_q;
    if (MemWriteM && sel == SEL_KEY_EDGE) key_edge_d = key_edge_d & ~WriteDataM[3:0];
    key_edge_d = key_edge_d | key_press;
  end

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (MemWriteM && sel == SEL_CYCLE) cycle_d = WriteDataM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ledr_q     <= '0;
      ledg_q     <= '0;
      hex_q      <= '0;
      lcd_q      <= '0;
      cycle_q    <= '0;
      key_edge_q <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      key_meta_q <= '1;
      key_sync_q <= '1;
      key_prev_q <= '1;
    end else begin
      sw_meta_q  <= io_sw;
      sw_sync_q  <= sw_meta_q;
      key_meta_q <= io_key;
      key_sync_q <= key_meta_q;
      key_prev_q <= key_sync_q;
      key_edge_q <= key_edge_d;
      cycle_q    <= cycle_d;
      if (MemWriteM) begin
        if (sel == SEL_LEDR)   ledr_q        <= WriteDataM;
        if (sel == SEL_LEDG)   ledg_q        <= WriteDataM;
        if (sel == SEL_HEX_LO) hex_q[31:0]   <= WriteDataM;
        if (sel == SEL_HEX_HI) hex_q[63:32]  <= WriteDataM;
        if (sel == SEL_LCD)    lcd_q         <= WriteDataM;
      end
    end
  end

  always_comb begin
    ReadDataM = '0;
    unique case (sel)
      SEL_DMEM:     ReadDataM = dmem_rdata;
      SEL_LEDR:     ReadDataM = ledr_q;
      SEL_LEDG:     ReadDataM = ledg_q;
      SEL_HEX_LO:   ReadDataM = hex_q[31:0];
      SEL_HEX_HI:   ReadDataM = hex_q[63:32];
      SEL_LCD:      ReadDataM = lcd_q;
      SEL_SW:       ReadDataM = sw_sync_q;
      SEL_KEY:      ReadDataM = {28'd0, ~key_sync_q};
      SEL_KEY_EDGE: ReadDataM = {28'd0, key_edge_q};
      SEL_CYCLE:    ReadDataM = cycle_q;
      default:      ReadDataM = '0;
    endcase
  end

  assign io_ledr = ledr_q;
  assign io_ledg = ledg_q;
  assign io_hex  = hex_q;
  assign io_lcd  = lcd_q;

endmodule
